// File: rtl/exc_commit_ctrl.sv
// rtl/exc_commit_ctrl.sv - WB-boundary exception/interrupt/ertn commit sequencer
module exc_commit_ctrl #(
  parameter int unsigned FLUSH_HOLD = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic [4:0]  wb_exc,
  input  logic        wb_is_ertn,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_pc,
  output logic        csr_wb_ex,
  output logic [5:0]  csr_ecode,
  output logic [8:0]  csr_esubcode,
  output logic [31:0] csr_epc,
  output logic        csr_ertn_flush,
  output logic        flush,
  output logic        redir_valid,
  output logic [31:0] redir_pc,
  input  logic        redir_ready,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_REDIR = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD - 1);

  localparam logic [5:0] EC_INT  = 6'h00;
  localparam logic [5:0] EC_ADEF = 6'h08;
  localparam logic [5:0] EC_INE  = 6'h0D;
  localparam logic [5:0] EC_SYS  = 6'h0B;
  localparam logic [5:0] EC_BRK  = 6'h0C;
  localparam logic [5:0] EC_ALE  = 6'h09;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        is_ertn_q, is_ertn_d;
  logic [31:0] target_q, target_d;
  logic        csr_wb_ex_q, csr_wb_ex_d;
  logic        csr_ertn_flush_q, csr_ertn_flush_d;
  logic [5:0]  csr_ecode_q, csr_ecode_d;
  logic [31:0] csr_epc_q, csr_epc_d;
  logic        flush_q, flush_d;
  logic        redir_valid_q, redir_valid_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        busy_q, busy_d;

  logic        has_exc;
  logic        take_exc;
  logic        wb_event;
  logic [5:0]  ecode_sel;
  logic        first_flush;
  logic [31:0] target_now;

  assign has_exc  = |wb_exc;
  assign take_exc = has_int | has_exc;
  assign wb_event = wb_valid & (take_exc | wb_is_ertn);

  // Resolve simultaneous causes to a single ecode, interrupt first
  always_comb begin
    ecode_sel = EC_ALE;
    if (has_int)        ecode_sel = EC_INT;
    else if (wb_exc[0]) ecode_sel = EC_ADEF;
    else if (wb_exc[1]) ecode_sel = EC_INE;
    else if (wb_exc[2]) ecode_sel = EC_SYS;
    else if (wb_exc[3]) ecode_sel = EC_BRK;
  end

  // The first FLUSH cycle is the one carrying the CSR pulse; the redirect
  // target is sampled then, so the CSR write caused by this event never
  // leaks into it.
  assign first_flush = csr_wb_ex_q | csr_ertn_flush_q;
  assign target_now  = first_flush ? (is_ertn_q ? ertn_pc : ex_entry) : target_q;

  // Next-state and registered-output logic for the commit sequence
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    is_ertn_d        = is_ertn_q;
    target_d         = target_q;
    csr_wb_ex_d      = 1'b0;
    csr_ertn_flush_d = 1'b0;
    csr_ecode_d      = csr_ecode_q;
    csr_epc_d        = csr_epc_q;
    flush_d          = 1'b0;
    redir_valid_d    = 1'b0;
    redir_pc_d       = redir_pc_q;

    case (state_q)
      S_IDLE: begin
        if (wb_event) begin
          state_d          = S_FLUSH;
          cnt_d            = HOLD_INIT;
          is_ertn_d        = ~take_exc;
          csr_wb_ex_d      = take_exc;
          csr_ertn_flush_d = ~take_exc;
          flush_d          = 1'b1;
          if (take_exc) begin
            csr_ecode_d = ecode_sel;
            csr_epc_d   = wb_pc;
          end
        end
      end
      S_FLUSH: begin
        if (first_flush) begin
          target_d = target_now;
        end
        if (cnt_q == 4'd0) begin
          state_d       = S_REDIR;
          redir_valid_d = 1'b1;
          redir_pc_d    = target_now;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
        end
      end
      S_REDIR: begin
        if (redir_ready) begin
          state_d = S_IDLE;
        end else begin
          redir_valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset clears everything, aborting any sequence
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= 4'd0;
      is_ertn_q        <= 1'b0;
      target_q         <= 32'd0;
      csr_wb_ex_q      <= 1'b0;
      csr_ertn_flush_q <= 1'b0;
      csr_ecode_q      <= 6'd0;
      csr_epc_q        <= 32'd0;
      flush_q          <= 1'b0;
      redir_valid_q    <= 1'b0;
      redir_pc_q       <= 32'd0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      is_ertn_q        <= is_ertn_d;
      target_q         <= target_d;
      csr_wb_ex_q      <= csr_wb_ex_d;
      csr_ertn_flush_q <= csr_ertn_flush_d;
      csr_ecode_q      <= csr_ecode_d;
      csr_epc_q        <= csr_epc_d;
      flush_q          <= flush_d;
      redir_valid_q    <= redir_valid_d;
      redir_pc_q       <= redir_pc_d;
      busy_q           <= busy_d;
    end
  end

  assign csr_wb_ex      = csr_wb_ex_q;
  assign csr_ecode      = csr_ecode_q;
  assign csr_esubcode   = 9'd0;
  assign csr_epc        = csr_epc_q;
  assign csr_ertn_flush = csr_ertn_flush_q;
  assign flush          = flush_q;
  assign redir_valid    = redir_valid_q;
  assign redir_pc       = redir_pc_q;
  assign busy           = busy_q;

endmodule

// File: doc/exc_commit_ctrl.md
Name: exc_commit_ctrl

Overview:
- Commit-point controller for exceptions, interrupts and ertn at the WB boundary; sequences the CSR exception unit and the pipeline flush.
- Resolves simultaneous causes of the WB instruction (plus pending interrupt) into one LoongArch ecode/esubcode.
- Pulses the CSR update, holds a pipeline-wide flush, then issues a handshaked redirect to pre-IF (exception entry or ertn return PC).

Parameters:
FLUSH_HOLD, 2, cycles the flush output stays high per event (legal range 1..15)

Ports:
clock  in  1  clock
reset  in  1  synchronous active-high reset
wb_valid  in  1  valid instruction in WB this cycle
wb_pc  in  32  PC of the WB instruction
wb_exc  in  5  exception flags: [0] ADEF, [1] INE, [2] SYS, [3] BRK, [4] ALE
wb_is_ertn  in  1  WB instruction is ertn
has_int  in  1  interrupt pending, from CSR block
ex_entry  in  32  exception entry address, from CSR block
ertn_pc  in  32  exception return address, from CSR block
csr_wb_ex  out  1  one-cycle exception commit pulse to CSR
csr_ecode  out  6  ecode for csr_wb_ex
csr_esubcode  out  9  esubcode for csr_wb_ex
csr_epc  out  32  exception PC for csr_wb_ex
csr_ertn_flush  out  1  one-cycle ertn commit pulse to CSR
flush  out  1  kill all in-flight instructions
redir_valid  out  1  redirect request to pre-IF
redir_pc  out  32  redirect target
redir_ready  in  1  pre-IF accepts redirect
busy  out  1  controller not IDLE; WB must stall

Behaviour:
- Reset (synchronous, active-high; clock clock): state IDLE; all outputs 0, including csr_ecode/csr_esubcode/csr_epc/redir_pc. Reset mid-sequence aborts immediately with no further pulses.
- Event detection, IDLE only: event = wb_valid & (has_int | |wb_exc | wb_is_ertn). wb_* and has_int are ignored outside IDLE and when wb_valid=0, so an interrupt is taken only against a valid WB instruction.
- Priority, highest first: INT (ecode 0x00) > ADEF (0x08) > INE (0x0D) > SYS (0x0B) > BRK (0x0C) > ALE (0x09) > ertn. esubcode is always 0. ertn counts only when no interrupt and no exception flag is set.
- States: IDLE -> FLUSH -> REDIR -> IDLE.
- IDLE with event at cycle T: latch the kind (exception or ertn), ecode and wb_pc; move to FLUSH at T+1.
- FLUSH (registered outputs, entered at T+1):
  - Exception: csr_wb_ex=1 at T+1 only, with csr_ecode, csr_esubcode=0 and csr_epc=latched pc valid during the pulse; csr_ertn_flush=0.
  - ertn: csr_ertn_flush=1 at T+1 only; csr_wb_ex=0.
  - flush=1 for exactly FLUSH_HOLD cycles, T+1 .. T+FLUSH_HOLD; a down-counter loads FLUSH_HOLD-1.
  - Redirect target is latched at T+1: ex_entry for an exception, ertn_pc for ertn. The CSR update from this event does not change either value.
  - Counter reaches 0 -> REDIR.
- REDIR: redir_valid=1 and redir_pc stay stable until redir_ready. The cycle with redir_valid & redir_ready is the last REDIR cycle; next cycle is IDLE with redir_valid=0. If redir_ready is low, hold indefinitely.
- busy = (state != IDLE), registered with the state. busy is 0 in the detection cycle T and 1 from T+1 through the handshake cycle.
- Back-to-back: an event can be detected in the first IDLE cycle after the handshake.
- Outside their pulse cycles, csr_wb_ex and csr_ertn_flush are 0. csr_ecode and csr_epc keep their last values (don't care).

Test Plan:
- SYS at wb_pc=0x1C000010, ex_entry=0x1C008000, FLUSH_HOLD=2, redir_ready=1 -> csr_wb_ex pulse at T+1 with ecode 0x0B, epc 0x1C000010; flush at T+1..T+2; redir_valid with pc 0x1C008000 at T+3; IDLE at T+4.
- has_int=1 with wb_exc=5'b00110 (INE+SYS) and wb_is_ertn=1 -> ecode 0x00; no csr_ertn_flush.
- wb_exc=5'b10001 (ADEF+ALE) -> ecode 0x08; wb_exc=5'b10000 alone -> ecode 0x09.
- ertn alone, ertn_pc=0x1C000100 -> csr_ertn_flush pulse at T+1 only, csr_wb_ex=0, redir_pc 0x1C000100.
- redir_ready low for 5 cycles -> redir_valid and redir_pc held stable, busy=1 throughout; new SYS with wb_valid during the wait is ignored (no second pulse).
- Reset asserted during FLUSH -> next cycle all outputs 0, state IDLE; then SYS with wb_valid=0 -> no response.
